// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start validation, centre sampling,
// and a one-entry valid/ready output register with framing-error and overrun pulses.
module uart_rx #(
    parameter int CLOCKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       serial_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       active_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int TW = $clog2(CLOCKS_PER_BIT);
    localparam int H  = CLOCKS_PER_BIT / 2;
    localparam logic [TW-1:0] T_FULL = TW'(CLOCKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_HALF = TW'(H - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            s1_q, rx_q;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            active_q, active_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            tick;
    logic            byte_done;
    logic            consume;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            s1_q      <= 1'b1;
            rx_q      <= 1'b1;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            s1_q      <= serial_i;
            rx_q      <= s1_q;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        active_d  = active_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;
        byte_done = 1'b0;
        tick      = (timer_q == '0);
        consume   = valid_q && ready_i;

        case (state_q)
            S_IDLE: begin
                if (!rx_q) begin
                    state_d  = S_START;
                    timer_d  = T_HALF;
                    active_d = 1'b1;
                end
            end
            S_START: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else if (!rx_q) begin
                    state_d   = S_DATA;
                    timer_d   = T_FULL;
                    bit_idx_d = '0;
                end else begin
                    // Line went back high before mid-bit: treat as a glitch.
                    state_d  = S_IDLE;
                    active_d = 1'b0;
                end
            end
            S_DATA: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    shift_d[bit_idx_q] = rx_q;
                    timer_d            = T_FULL;
                    if (bit_idx_q == 3'd7) begin
                        state_d   = S_STOP;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (!tick) begin
                    timer_d = timer_q - 1'b1;
                end else begin
                    timer_d  = T_FULL;
                    active_d = 1'b0;
                    if (rx_q) begin
                        byte_done = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Hold off start detection until the line returns high.
                if (rx_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                active_d = 1'b0;
            end
        endcase

        // A completing byte always wins the output register; overrun only if the old one was not taken.
        if (byte_done) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ovr_d   = valid_q && !ready_i;
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign active_o    = active_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed corner sequences, a vector table and
// randomized frames checked against a byte-level model of the receiver's output register.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       serial_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       active_o;
    logic       frame_err_o;
    logic       overrun_o;

    always #5 clk = ~clk;

    uart_rx #(.CLOCKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_i   (serial_i),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .active_o   (active_o),
        .frame_err_o(frame_err_o),
        .overrun_o  (overrun_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Event counters observed on the falling edge
    int         ferr_cnt = 0, ovr_cnt = 0, vrise_cnt = 0, vcyc_cnt = 0;
    int         act_rise_cnt = 0, act_cyc_cnt = 0, low_run = 0, last_gap = 0;
    logic       v_prev = 1'b0, a_prev = 1'b0;
    logic [7:0] last_rise_data = 8'h00;

    always @(negedge clk) begin
        if (frame_err_o) ferr_cnt++;
        if (overrun_o) ovr_cnt++;
        if (valid_o && !v_prev) begin
            vrise_cnt++;
            last_rise_data = data_o;
        end
        if (valid_o) vcyc_cnt++;
        if (active_o) begin
            act_cyc_cnt++;
            if (!a_prev) begin
                act_rise_cnt++;
                last_gap = low_run;
            end
            low_run = 0;
        end else begin
            low_run++;
        end
        v_prev = valid_o;
        a_prev = active_o;
    end

    int b_ferr, b_ovr, b_vrise, b_vcyc, b_arise, b_acyc;

    task automatic snap();
        b_ferr  = ferr_cnt;
        b_ovr   = ovr_cnt;
        b_vrise = vrise_cnt;
        b_vcyc  = vcyc_cnt;
        b_arise = act_rise_cnt;
        b_acyc  = act_cyc_cnt;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low);
        serial_i = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            serial_i = b[i];
            cycles(CPB);
        end
        serial_i = stop_ok;
        cycles(CPB);
        if (!stop_ok) begin
            cycles(extra_low);
            serial_i = 1'b1;
        end
    endtask

    task automatic consume_pulse();
        ready_i = 1'b1;
        cycles(1);
        ready_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " data_o"}, 32'(data_o), 0);
        check({tag, " valid_o"}, 32'(valid_o), 0);
        check({tag, " active_o"}, 32'(active_o), 0);
        check({tag, " frame_err_o"}, 32'(frame_err_o), 0);
        check({tag, " overrun_o"}, 32'(overrun_o), 0);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         consume;
        bit         exp_valid;
        logic [7:0] exp_data;
        bit         exp_ferr;
        bit         exp_ovr;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         lat;
        bit         m_valid;
        logic [7:0] m_data;
        logic [7:0] rb;
        bit         rok, rcons, e_ovr, e_rise;
        logic [7:0] b2b[3];

        vecs[0] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[1] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1};
        vecs[2] = '{8'h81, 1'b0, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0};
        vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'h5A, 1'b0, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[8] = '{8'h96, 1'b1, 1'b1, 1'b1, 8'h96, 1'b0, 1'b1};

        reset    = 1'b1;
        serial_i = 1'b1;
        ready_i  = 1'b0;
        cycles(5);
        check_all_zero("reset");
        reset = 1'b0;
        cycles(5);

        // 0xA5 latency and hold-until-consumed
        snap();
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                while (!valid_o && lat < 300) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check_range("a5 latency", lat, 154, 156);
        cycles(20);
        check("a5 valid held", 32'(valid_o), 1);
        check("a5 data", 32'(data_o), 32'hA5);
        consume_pulse();
        check("a5 valid after ready", 32'(valid_o), 0);
        #1;
        check("a5 ferr count", 32'(ferr_cnt - b_ferr), 0);
        check("a5 ovr count", 32'(ovr_cnt - b_ovr), 0);

        // Back-to-back frames with ready held high
        b2b[0] = 8'h00;
        b2b[1] = 8'hFF;
        b2b[2] = 8'h5A;
        ready_i = 1'b1;
        snap();
        for (int i = 0; i < 3; i++) begin
            send_frame(b2b[i], 1'b1, 0);
            #1;
            check("b2b valid count", 32'(vrise_cnt - b_vrise), 32'(i + 1));
            check("b2b data", 32'(last_rise_data), 32'(b2b[i]));
            if (i > 0) check_range("b2b active gap", last_gap, 1, H + 2);
        end
        cycles(20);
        #1;
        check("b2b valid cycles", 32'(vcyc_cnt - b_vcyc), 3);
        check("b2b ovr count", 32'(ovr_cnt - b_ovr), 0);
        ready_i = 1'b0;

        // Short low glitch on an idle line
        snap();
        serial_i = 1'b0;
        cycles(3);
        serial_i = 1'b1;
        cycles(H + 30);
        #1;
        check("glitch active pulses", 32'(act_rise_cnt - b_arise), 1);
        check_range("glitch active len", act_cyc_cnt - b_acyc, H - 1, H + 4);
        check("glitch no valid", 32'(vrise_cnt - b_vrise), 0);
        check("glitch no ferr", 32'(ferr_cnt - b_ferr), 0);
        send_frame(8'h3C, 1'b1, 0);
        cycles(5);
        check("post-glitch valid", 32'(valid_o), 1);
        check("post-glitch data", 32'(data_o), 32'h3C);
        consume_pulse();

        // Vector table
        for (int i = 0; i < 9; i++) begin
            snap();
            send_frame(vecs[i].data, vecs[i].stop_ok, 40);
            cycles(20);
            #1;
            check("vec valid", 32'(valid_o), 32'(vecs[i].exp_valid));
            check("vec data", 32'(data_o), 32'(vecs[i].exp_data));
            check("vec ferr", 32'(ferr_cnt - b_ferr), 32'(vecs[i].exp_ferr));
            check("vec ovr", 32'(ovr_cnt - b_ovr), 32'(vecs[i].exp_ovr));
            if (!vecs[i].stop_ok)
                check("vec break no restart", 32'(act_rise_cnt - b_arise), 1);
            if (vecs[i].consume) consume_pulse();
        end

        // Reset during the last data bit of 0x77
        send_frame(8'h3C, 1'b1, 0);
        cycles(5);
        snap();
        serial_i = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 7; i++) begin
            rb = 8'h77;
            serial_i = rb[i];
            cycles(CPB);
        end
        serial_i = 1'b0;
        cycles(9);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        #1;
        check_all_zero("mid-frame reset");
        cycles(6);
        serial_i = 1'b1;
        cycles(CPB + 40);
        #1;
        check("reset no valid", 32'(vrise_cnt - b_vrise), 0);
        check("reset no ferr", 32'(ferr_cnt - b_ferr), 0);
        check("reset valid low", 32'(valid_o), 0);
        send_frame(8'h96, 1'b1, 0);
        cycles(5);
        check("post-reset valid", 32'(valid_o), 1);
        check("post-reset data", 32'(data_o), 32'h96);
        consume_pulse();

        // Randomized frames against a byte-level model
        m_valid = 1'b0;
        m_data  = 8'h96;
        for (int n = 0; n < 24; n++) begin
            rb    = 8'($urandom_range(0, 255));
            rok   = ($urandom_range(0, 5) != 0);
            rcons = 1'($urandom_range(0, 1));
            e_ovr  = rok && m_valid;
            e_rise = rok && !m_valid;
            if (rok) begin
                m_valid = 1'b1;
                m_data  = rb;
            end
            snap();
            send_frame(rb, rok, 20);
            cycles(20);
            #1;
            check("rand valid", 32'(valid_o), 32'(m_valid));
            check("rand data", 32'(data_o), 32'(m_data));
            check("rand ferr", 32'(ferr_cnt - b_ferr), 32'(!rok));
            check("rand ovr", 32'(ovr_cnt - b_ovr), 32'(e_ovr));
            check("rand valid rise", 32'(vrise_cnt - b_vrise), 32'(e_rise));
            if (rcons) begin
                consume_pulse();
                m_valid = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
